// File: rtl/led7seg_pkg.sv
// ----------------------------------------------------------------------------
// led7seg_pkg
// Shared types and constants for the 74HC595 seven-segment scan driver.
//   scan_state_e    : scan FSM states (LOAD, SLO, SHI, LAT, LEND)
//   CHA_WIDTH       : bits shifted per digit (segment byte + digit-select byte)
//   DAT_WIDTH       : width of the full segment frame
//   DIG_IDX_W       : width of the digit index
//   TICKS_PER_DIGIT : ticks spent on one digit, LOAD included
// ----------------------------------------------------------------------------
package led7seg_pkg;

    localparam int unsigned DIG_NUM_DEF     = 8;
    localparam int unsigned SEG_NUM_DEF     = 8;
    localparam int unsigned CHA_WIDTH       = SEG_NUM_DEF + DIG_NUM_DEF;
    localparam int unsigned DAT_WIDTH       = SEG_NUM_DEF * DIG_NUM_DEF;
    localparam int unsigned DIG_IDX_W       = $clog2(DIG_NUM_DEF);
    localparam int unsigned TICKS_PER_DIGIT = 2 * CHA_WIDTH + 3;

    typedef enum logic [2:0] {
        LOAD,
        SLO,
        SHI,
        LAT,
        LEND
    } scan_state_e;

endpackage

// File: rtl/led7seg_hc595_scan_driver_tick_gen.sv
// ----------------------------------------------------------------------------
// led7seg_tick_gen
// Free-running power-of-two divider; tick_o is high for one clk on every wrap,
// i.e. once every 2**DIV_WIDTH clk cycles.
//   clk_i  : system clock
//   rst_i  : asynchronous active-high reset (counter cleared to 0)
//   tick_o : scan-rate enable
// ----------------------------------------------------------------------------
module led7seg_tick_gen #(
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    output logic tick_o
);

    logic [DIV_WIDTH-1:0] cnt_q;
    logic [DIV_WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + DIV_WIDTH'(1);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = &cnt_q;

endmodule

// File: rtl/led7seg_hc595_scan_driver.sv
// ----------------------------------------------------------------------------
// led7seg_hc595_scan_driver
// Scans an 8-digit segment frame onto two chained 74HC595s, one digit at a
// time, MSB first: {segment byte of digit d, one-hot digit select}.
// A new frame is adopted only at the digit-0 LOAD, so a frame is never torn.
//   clk        : system clock
//   rst        : asynchronous active-high reset
//   dat        : frame; byte d is the segment pattern of digit d
//   vld        : dat valid, sampled every clk (last one before a boundary wins)
//   sclk       : 595 shift clock
//   rclk       : 595 storage clock
//   dio        : 595 serial data
//   frame_done : 1-clk pulse after the last digit is latched
// Build option: LED7SEG_DIG_ACTIVE_LOW_EN inverts the digit-select byte for
// common-anode boards with PNP digit drivers.
// ----------------------------------------------------------------------------
module led7seg_hc595_scan_driver
    import led7seg_pkg::*;
#(
    parameter int unsigned DIG_NUM   = DIG_NUM_DEF,
    parameter int unsigned SEG_NUM   = SEG_NUM_DEF,
    parameter int unsigned DIV_WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [SEG_NUM*DIG_NUM-1:0] dat,
    input  logic                       vld,
    output logic                       sclk,
    output logic                       rclk,
    output logic                       dio,
    output logic                       frame_done
);

    localparam int unsigned CHA_W = SEG_NUM + DIG_NUM;
    localparam int unsigned IDX_W = (DIG_NUM > 1) ? $clog2(DIG_NUM) : 1;
    localparam int unsigned CNT_W = $clog2(CHA_W);

    logic                       tick;
    scan_state_e                state_q, state_d;
    logic [IDX_W-1:0]           dig_q, dig_d;
    logic [CNT_W-1:0]           bit_q, bit_d;
    logic [CHA_W-1:0]           shreg_q, shreg_d;
    logic [SEG_NUM*DIG_NUM-1:0] shadow_q, shadow_d;
    logic [SEG_NUM*DIG_NUM-1:0] frame_q, frame_d;
    logic                       sclk_q, sclk_d;
    logic                       rclk_q, rclk_d;
    logic                       dio_q, dio_d;
    logic                       fdone_q, fdone_d;

    logic [SEG_NUM*DIG_NUM-1:0] frame_sel;
    logic [DIG_NUM-1:0]         dig_sel;
    logic                       last_dig;

    led7seg_tick_gen #(
        .DIV_WIDTH(DIV_WIDTH)
    ) u_tick (
        .clk_i (clk),
        .rst_i (rst),
        .tick_o(tick)
    );

    assign last_dig = (dig_q == IDX_W'(DIG_NUM - 1));

    // At digit 0 the word is built from the frame being adopted in the same
    // tick, so a vld coinciding with the boundary lands in this frame.
    always_comb begin
        frame_sel = (dig_q == '0) ? (vld ? dat : shadow_q) : frame_q;
`ifdef LED7SEG_DIG_ACTIVE_LOW_EN
        dig_sel = ~(DIG_NUM'(1) << dig_q);
`else
        dig_sel = DIG_NUM'(1) << dig_q;
`endif
    end

    always_comb begin
        state_d  = state_q;
        dig_d    = dig_q;
        bit_d    = bit_q;
        shreg_d  = shreg_q;
        frame_d  = frame_q;
        sclk_d   = sclk_q;
        rclk_d   = rclk_q;
        dio_d    = dio_q;
        fdone_d  = 1'b0;
        shadow_d = vld ? dat : shadow_q;

        if (tick) begin
            case (state_q)
                LOAD: begin
                    frame_d = frame_sel;
                    shreg_d = {frame_sel[dig_q*SEG_NUM +: SEG_NUM], dig_sel};
                    bit_d   = '0;
                    state_d = SLO;
                end
                SLO: begin
                    sclk_d  = 1'b0;
                    dio_d   = shreg_q[CHA_W-1];
                    state_d = SHI;
                end
                SHI: begin
                    sclk_d  = 1'b1;
                    shreg_d = shreg_q << 1;
                    bit_d   = bit_q + CNT_W'(1);
                    state_d = (bit_q == CNT_W'(CHA_W - 1)) ? LAT : SLO;
                end
                LAT: begin
                    sclk_d  = 1'b0;
                    rclk_d  = 1'b1;
                    state_d = LEND;
                end
                LEND: begin
                    rclk_d  = 1'b0;
                    dig_d   = last_dig ? '0 : dig_q + IDX_W'(1);
                    fdone_d = last_dig;
                    state_d = LOAD;
                end
                default: begin
                    state_d = LOAD;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= LOAD;
            dig_q    <= '0;
            bit_q    <= '0;
            shreg_q  <= '0;
            shadow_q <= '0;
            frame_q  <= '0;
            sclk_q   <= 1'b0;
            rclk_q   <= 1'b0;
            dio_q    <= 1'b0;
            fdone_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            dig_q    <= dig_d;
            bit_q    <= bit_d;
            shreg_q  <= shreg_d;
            shadow_q <= shadow_d;
            frame_q  <= frame_d;
            sclk_q   <= sclk_d;
            rclk_q   <= rclk_d;
            dio_q    <= dio_d;
            fdone_q  <= fdone_d;
        end
    end

    assign sclk       = sclk_q;
    assign rclk       = rclk_q;
    assign dio        = dio_q;
    assign frame_done = fdone_q;

endmodule

// File: tb/tb_led7seg_hc595_scan_driver.sv
// ----------------------------------------------------------------------------
// tb_led7seg_hc595_scan_driver
// Directed bench for the 595 scan driver with DIV_WIDTH=2 (tick every 4 clk).
// A decoder rebuilds each 16-bit word from sclk/dio and captures it on rclk.
// Build option: LED7SEG_DIG_ACTIVE_LOW_EN (expected words use inverted select).
// ----------------------------------------------------------------------------
module tb_led7seg_hc595_scan_driver;

    localparam logic [63:0] FA = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] FB = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] FC = 64'h1122_3344_5566_7788;
    localparam logic [63:0] FD = 64'hA5A5_5A5A_C3C3_3C3C;
    localparam logic [63:0] FE = 64'h0F1E_2D3C_4B5A_6978;

`ifdef LED7SEG_DIG_ACTIVE_LOW_EN
    localparam logic [15:0] W0_FA = 16'hEFFE;
    localparam logic [15:0] W7_FA = 16'h017F;
    localparam logic [15:0] W0_Z  = 16'h00FE;
    localparam logic [15:0] W1_Z  = 16'h00FD;
`else
    localparam logic [15:0] W0_FA = 16'hEF01;
    localparam logic [15:0] W7_FA = 16'h0180;
    localparam logic [15:0] W0_Z  = 16'h0001;
    localparam logic [15:0] W1_Z  = 16'h0002;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] dat = '0;
    logic        vld = 1'b0;
    logic        sclk, rclk, dio, frame_done;

    int errors = 0;
    int checks = 0;

    always #4 clk = ~clk;

    led7seg_hc595_scan_driver #(
        .DIG_NUM  (8),
        .SEG_NUM  (8),
        .DIV_WIDTH(2)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .dat       (dat),
        .vld       (vld),
        .sclk      (sclk),
        .rclk      (rclk),
        .dio       (dio),
        .frame_done(frame_done)
    );

    // Decoder: sampled on the falling edge, away from the active edge.
    logic [15:0] sh = '0;
    int          nbits = 0;
    logic        sclk_p = 1'b0, rclk_p = 1'b0, fd_p = 1'b0;
    logic [15:0] words[$];
    int          wbits[$];
    int          fd_t[$];
    int          fd_cnt = 0;
    int          cyc = 0;
    bit          fd_wide = 1'b0;

    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                sh = '0; nbits = 0; sclk_p = 1'b0; rclk_p = 1'b0; fd_p = 1'b0;
            end else begin
                if (sclk && !sclk_p) begin
                    sh = {sh[14:0], dio};
                    nbits++;
                end
                if (rclk && !rclk_p) begin
                    words.push_back(sh);
                    wbits.push_back(nbits);
                    nbits = 0;
                end
                if (frame_done) begin
                    if (fd_p) fd_wide = 1'b1;
                    fd_cnt++;
                    fd_t.push_back(cyc);
                end
                sclk_p = sclk; rclk_p = rclk; fd_p = frame_done;
            end
        end
    end

    function automatic logic [15:0] exp_word(input logic [63:0] f, input int d);
        logic [7:0] sel;
        sel = 8'h01 << d;
`ifdef LED7SEG_DIG_ACTIVE_LOW_EN
        sel = ~sel;
`endif
        return {f[8*d +: 8], sel};
    endfunction

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_capture();
        words.delete();
        wbits.delete();
        fd_t.delete();
    endtask

    task automatic wait_words(input int n, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 6000; i++) begin
            step(1);
            if (words.size() >= n) begin ok = 1'b1; break; end
        end
    endtask

    task automatic wait_fd(output bit ok);
        int start;
        start = fd_cnt;
        ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            step(1);
            if (fd_cnt != start) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step(3);
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL reset_sclk: got %b expected 0", sclk); end
        checks++; if (rclk !== 1'b0) begin errors++; $display("FAIL reset_rclk: got %b expected 0", rclk); end
        checks++; if (dio !== 1'b0) begin errors++; $display("FAIL reset_dio: got %b expected 0", dio); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        rst = 1'b0;
        clear_capture();
        step(2);
        checks++; if (sclk !== 1'b0 || rclk !== 1'b0) begin errors++; $display("FAIL reset_idle_before_tick: got sclk=%b rclk=%b expected 0 0", sclk, rclk); end
    endtask

    task automatic test_first_frame();
        bit ok;
        dat = FA; vld = 1'b1;
        step(1);
        vld = 1'b0; dat = '0;
        wait_words(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL first_frame_timeout: got %0d words expected 8", words.size()); end
        checks++; if (words[0] !== W0_FA) begin errors++; $display("FAIL first_word: got %h expected %h", words[0], W0_FA); end
        checks++; if (words[7] !== W7_FA) begin errors++; $display("FAIL digit7_word: got %h expected %h", words[7], W7_FA); end
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (words[d] !== exp_word(FA, d) || wbits[d] != 16) begin
                errors++;
                $display("FAIL first_frame_d%0d: got %h/%0d bits expected %h/16", d, words[d], wbits[d], exp_word(FA, d));
            end
        end
    endtask

    task automatic test_free_run();
        bit ok;
        wait_fd(ok);
        clear_capture();
        for (int k = 0; k < 3; k++) begin
            wait_fd(ok);
            checks++; if (!ok) begin errors++; $display("FAIL free_run_fd_timeout: got no pulse expected pulse %0d", k); end
        end
        checks++; if (fd_t[1] - fd_t[0] != 1120) begin errors++; $display("FAIL frame_period_a: got %0d expected 1120", fd_t[1] - fd_t[0]); end
        checks++; if (fd_t[2] - fd_t[1] != 1120) begin errors++; $display("FAIL frame_period_b: got %0d expected 1120", fd_t[2] - fd_t[1]); end
        checks++; if (fd_wide !== 1'b0) begin errors++; $display("FAIL frame_done_width: got wide pulse expected 1 clk"); end
        checks++; if (words.size() != 24) begin errors++; $display("FAIL free_run_words: got %0d expected 24", words.size()); end
        for (int i = 0; i < 24; i++) begin
            checks++;
            if (wbits[i] != 16 || words[i] !== exp_word(FA, i % 8)) begin
                errors++;
                $display("FAIL free_run_w%0d: got %h/%0d bits expected %h/16", i, words[i], wbits[i], exp_word(FA, i % 8));
            end
        end
    endtask

    task automatic test_mid_frame_update();
        bit ok;
        wait_fd(ok);
        clear_capture();
        wait_words(3, ok);
        step(20);
        dat = FB; vld = 1'b1;
        step(1);
        vld = 1'b0; dat = '0;
        wait_words(16, ok);
        checks++; if (!ok) begin errors++; $display("FAIL mid_update_timeout: got %0d words expected 16", words.size()); end
        for (int i = 3; i < 16; i++) begin
            checks++;
            if (words[i] !== exp_word((i < 8) ? FA : FB, i % 8)) begin
                errors++;
                $display("FAIL mid_update_w%0d: got %h expected %h", i, words[i], exp_word((i < 8) ? FA : FB, i % 8));
            end
        end
    endtask

    // frame_done is seen one clk after the LEND tick; LOAD follows 4 clk after LEND.
    task automatic test_boundary_update();
        bit ok;
        wait_fd(ok);
        clear_capture();
        step(2);
        dat = FC; vld = 1'b1;
        step(1);
        vld = 1'b0; dat = '0;
        wait_words(8, ok);
        checks++; if (!ok) begin errors++; $display("FAIL boundary_timeout: got %0d words expected 8", words.size()); end
        for (int d = 0; d < 8; d++) begin
            checks++;
            if (words[d] !== exp_word(FC, d)) begin
                errors++;
                $display("FAIL boundary_d%0d: got %h expected %h", d, words[d], exp_word(FC, d));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        wait_fd(ok);
        clear_capture();
        step(50);
        dat = FD; vld = 1'b1;
        step(1);
        dat = FE;
        step(1);
        vld = 1'b0; dat = '0;
        wait_words(16, ok);
        checks++; if (words[0] !== exp_word(FC, 0)) begin errors++; $display("FAIL b2b_old_frame: got %h expected %h", words[0], exp_word(FC, 0)); end
        for (int i = 8; i < 16; i++) begin
            checks++;
            if (words[i] !== exp_word(FE, i % 8)) begin
                errors++;
                $display("FAIL b2b_last_wins_w%0d: got %h expected %h", i, words[i], exp_word(FE, i % 8));
            end
        end
    endtask

    task automatic test_reset_mid_shift();
        bit ok;
        wait_fd(ok);
        clear_capture();
        wait_words(5, ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (nbits == 7) begin ok = 1'b1; break; end
            step(1);
        end
        checks++; if (!ok || sclk !== 1'b1) begin errors++; $display("FAIL mid_shift_reach: got bits=%0d sclk=%b expected 7 1", nbits, sclk); end
        rst = 1'b1;
        #1;
        checks++; if (sclk !== 1'b0) begin errors++; $display("FAIL abort_sclk: got %b expected 0", sclk); end
        checks++; if (rclk !== 1'b0 || dio !== 1'b0) begin errors++; $display("FAIL abort_rclk_dio: got %b %b expected 0 0", rclk, dio); end
        step(3);
        rst = 1'b0;
        clear_capture();
        wait_words(2, ok);
        checks++; if (!ok) begin errors++; $display("FAIL restart_timeout: got %0d words expected 2", words.size()); end
        checks++; if (words[0] !== W0_Z || wbits[0] != 16) begin errors++; $display("FAIL restart_d0: got %h/%0d bits expected %h/16", words[0], wbits[0], W0_Z); end
        checks++; if (words[1] !== W1_Z) begin errors++; $display("FAIL restart_d1: got %h expected %h", words[1], W1_Z); end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_free_run();
        test_mid_frame_update();
        test_boundary_update();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
